// File: rtl/coord_entry_sequencer.sv
// Coordinate-entry controller: captures up to four (X,Y) points and rotates them onto one display path.
// Optional target compare on the hit output is enabled by defining TARGET_MATCH_EN.
module coord_entry_sequencer #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter logic [3:0]  TARGET_X     = 4'h2,
  parameter logic [3:0]  TARGET_Y     = 4'h8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       enter,
  output logic [3:0] disp_x,
  output logic [3:0] disp_y,
  output logic [1:0] disp_slot,
  output logic       disp_valid,
  output logic [2:0] count,
  output logic       full,
  output logic       overflow,
  output logic       hit
);

  localparam int unsigned CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

  state_t              state, state_n;
  logic [3:0][3:0]     slot_x, slot_x_n, slot_y, slot_y_n;
  logic [2:0]          count_n;
  logic [1:0]          disp_slot_n;
  logic [CW-1:0]       dwell, dwell_n;
  logic                enter_q;
  logic                overflow_n, hit_n, full_n, disp_valid_n;
  logic [3:0]          disp_x_n, disp_y_n;
  logic                capture, zero_pt;

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      slot_x     <= '0;
      slot_y     <= '0;
      count      <= 3'd0;
      disp_slot  <= 2'd0;
      dwell      <= '0;
      enter_q    <= 1'b0;
      overflow   <= 1'b0;
      hit        <= 1'b0;
      full       <= 1'b0;
      disp_valid <= 1'b0;
      disp_x     <= 4'd0;
      disp_y     <= 4'd0;
    end else begin
      state      <= state_n;
      slot_x     <= slot_x_n;
      slot_y     <= slot_y_n;
      count      <= count_n;
      disp_slot  <= disp_slot_n;
      dwell      <= dwell_n;
      enter_q    <= enter;
      overflow   <= overflow_n;
      hit        <= hit_n;
      full       <= full_n;
      disp_valid <= disp_valid_n;
      disp_x     <= disp_x_n;
      disp_y     <= disp_y_n;
    end
  end

  // Next-state: capture events take priority over the dwell rotation
  always_comb begin
    state_n     = state;
    slot_x_n    = slot_x;
    slot_y_n    = slot_y;
    count_n     = count;
    disp_slot_n = disp_slot;
    dwell_n     = dwell;
    overflow_n  = overflow;
    capture     = enter & ~enter_q;
    zero_pt     = (X == 4'd0) && (Y == 4'd0);

    if (capture && zero_pt) begin
      state_n     = EMPTY;
      count_n     = 3'd0;
      disp_slot_n = 2'd0;
      dwell_n     = '0;
      overflow_n  = 1'b0;
    end else if (capture && state != FULL) begin
      slot_x_n[count[1:0]] = X;
      slot_y_n[count[1:0]] = Y;
      count_n     = count + 3'd1;
      disp_slot_n = count[1:0];
      dwell_n     = '0;
      state_n     = (count == 3'd3) ? FULL : FILL;
    end else begin
      if (capture) begin
        overflow_n = 1'b1;
      end
      if (state != EMPTY) begin
        if (dwell == DWELL_LAST) begin
          dwell_n     = '0;
          disp_slot_n = (({1'b0, disp_slot} + 3'd1) == count) ? 2'd0 : disp_slot + 2'd1;
        end else begin
          dwell_n = dwell + CW'(1);
        end
      end
    end

    full_n       = (count_n == 3'd4);
    disp_valid_n = (state_n != EMPTY);
    disp_x_n     = disp_valid_n ? slot_x_n[disp_slot_n] : 4'd0;
    disp_y_n     = disp_valid_n ? slot_y_n[disp_slot_n] : 4'd0;
  end

`ifdef TARGET_MATCH_EN
  logic match;

  // Target compare over the currently valid slots; hit follows one edge later
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < count) && (slot_x[i] == TARGET_X) && (slot_y[i] == TARGET_Y)) begin
        match = 1'b1;
      end
    end
    hit_n = (capture && zero_pt) ? 1'b0 : match;
  end
`else
  logic [7:0] unused_target;
  assign unused_target = {TARGET_X, TARGET_Y};

  always_comb begin
    hit_n = 1'b0;
  end
`endif

endmodule

// File: tb/tb_coord_entry_sequencer.sv
// Bench for coord_entry_sequencer: queue-based point model checked every cycle plus directed literal checks.
module tb_coord_entry_sequencer;

  localparam int unsigned DWELL = 4;
  localparam logic [3:0] TX = 4'h2;
  localparam logic [3:0] TY = 4'h8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] X = 4'd0;
  logic [3:0] Y = 4'd0;
  logic       enter = 1'b0;
  logic [3:0] disp_x, disp_y;
  logic [1:0] disp_slot;
  logic       disp_valid, full, overflow, hit;
  logic [2:0] count;

  coord_entry_sequencer #(.DWELL_CYCLES(DWELL), .TARGET_X(TX), .TARGET_Y(TY)) dut (
    .clock(clock), .reset(reset), .X(X), .Y(Y), .enter(enter),
    .disp_x(disp_x), .disp_y(disp_y), .disp_slot(disp_slot), .disp_valid(disp_valid),
    .count(count), .full(full), .overflow(overflow), .hit(hit)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: stored points as a queue, shown index and time on the current point
  typedef struct packed {logic [3:0] x; logic [3:0] y;} pt_t;
  pt_t pts[$];
  int  shown = 0;
  int  dwell = 0;
  bit  prev_en = 1'b0;
  bit  m_ovf = 1'b0;
  bit  m_hit = 1'b0;

  always @(posedge clock or negedge reset) begin
    bit ev, any;
    if (!reset) begin
      pts.delete();
      shown = 0; dwell = 0; prev_en = 1'b0; m_ovf = 1'b0; m_hit = 1'b0;
    end else begin
      ev = enter && !prev_en;
      prev_en = enter;
      any = 1'b0;
      foreach (pts[i]) if (pts[i].x == TX && pts[i].y == TY) any = 1'b1;
`ifdef TARGET_MATCH_EN
      m_hit = any;
`else
      m_hit = 1'b0;
`endif
      if (ev && X == 0 && Y == 0) begin
        pts.delete();
        shown = 0; dwell = 0; m_ovf = 1'b0; m_hit = 1'b0;
      end else if (ev && pts.size() < 4) begin
        pts.push_back('{x: X, y: Y});
        shown = pts.size() - 1;
        dwell = 0;
      end else begin
        if (ev) m_ovf = 1'b1;
        if (pts.size() > 0) begin
          dwell = dwell + 1;
          if (dwell == DWELL) begin
            dwell = 0;
            shown = (shown + 1) % pts.size();
          end
        end
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clock) begin
    if (model_on) begin
      chk("count", count, pts.size());
      chk("full", full, pts.size() == 4);
      chk("overflow", overflow, m_ovf);
      chk("disp_valid", disp_valid, pts.size() > 0);
      chk("disp_slot", disp_slot, pts.size() > 0 ? shown : 0);
      chk("disp_x", disp_x, pts.size() > 0 ? int'(pts[shown].x) : 0);
      chk("disp_y", disp_y, pts.size() > 0 ? int'(pts[shown].y) : 0);
      chk("hit", hit, m_hit);
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic pulse(input logic [3:0] px, input logic [3:0] py);
    X = px; Y = py; enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask

  int exp_hit;
  bit seen9, seen_d;

  initial begin
`ifdef TARGET_MATCH_EN
    exp_hit = 1;
`else
    exp_hit = 0;
`endif
    repeat (2) tick();
    chk("rst_count", count, 0);
    chk("rst_valid", disp_valid, 0);
    chk("rst_disp_x", disp_x, 0);
    chk("rst_overflow", overflow, 0);
    model_on = 1'b1;
    reset = 1'b1;
    tick();

    // Two entries and rotation
    pulse(4'd3, 4'd5);
    pulse(4'd7, 4'd1);
    chk("t1_count", count, 2);
    chk("t1_slot_new", disp_slot, 1);
    chk("t1_x_new", disp_x, 7);
    chk("t1_y_new", disp_y, 1);
    repeat (3) tick();
    chk("t1_slot_rot", disp_slot, 0);
    chk("t1_x_rot", disp_x, 3);
    chk("t1_y_rot", disp_y, 5);
    repeat (4) tick();
    chk("t1_slot_back", disp_slot, 1);
    chk("t1_x_back", disp_x, 7);

    // Held enter gives one capture
    pulse(4'd0, 4'd0);
    X = 4'd4; Y = 4'd4; enter = 1'b1;
    repeat (20) tick();
    enter = 1'b0;
    tick();
    chk("t2_count", count, 1);
    chk("t2_slot", disp_slot, 0);
    chk("t2_x", disp_x, 4);

    // Fill to four then overflow
    pulse(4'd0, 4'd0);
    pulse(4'd1, 4'd1);
    pulse(4'd2, 4'd2);
    pulse(4'd3, 4'd3);
    pulse(4'd4, 4'd4);
    pulse(4'd9, 4'd9);
    chk("t3_count", count, 4);
    chk("t3_full", full, 1);
    chk("t3_overflow", overflow, 1);
    seen9 = 1'b0; seen_d = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (disp_x == 4'd9) seen9 = 1'b1;
      if (disp_slot == 2'd3 && disp_x == 4'd4 && disp_y == 4'd4) seen_d = 1'b1;
    end
    chk("t3_never_99", seen9, 0);
    chk("t3_slot_d_44", seen_d, 1);

    // Clear from FULL, visible after the capturing edge
    X = 4'd0; Y = 4'd0; enter = 1'b1;
    tick();
    chk("t4_count", count, 0);
    chk("t4_full", full, 0);
    chk("t4_overflow", overflow, 0);
    chk("t4_valid", disp_valid, 0);
    chk("t4_x", disp_x, 0);
    chk("t4_y", disp_y, 0);
    enter = 1'b0;
    tick();

    // Asynchronous reset mid-dwell
    pulse(4'd1, 4'd2);
    pulse(4'd3, 4'd4);
    pulse(4'd5, 4'd6);
    tick();
    chk("t5_count_pre", count, 3);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_count", count, 0);
    chk("t5_async_valid", disp_valid, 0);
    chk("t5_async_x", disp_x, 0);
    chk("t5_async_slot", disp_slot, 0);
    tick();
    reset = 1'b1;
    pulse(4'd6, 4'd6);
    chk("t5_first_count", count, 1);
    chk("t5_first_slot", disp_slot, 0);
    chk("t5_first_x", disp_x, 6);

    // Target match
    pulse(4'd0, 4'd0);
    pulse(4'd5, 4'd5);
    chk("t6_hit_first", hit, 0);
    pulse(4'd2, 4'd8);
    chk("t6_hit_second", hit, exp_hit);
    pulse(4'd0, 4'd0);
    chk("t6_hit_clear", hit, 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/coord_entry_sequencer.md
Name: coord_entry_sequencer

Overview:
- Controller for the coordinate-entry datapath.
- Captures up to four 4-bit (X,Y) point pairs, one per rising edge of an enter strobe, into slots A–D.
- An entry of "0,0" clears all slots.
- Time-multiplexes the stored points onto one shared display path: the downstream seven-segment decoders feed H1..H6.

Parameters:
- DWELL_CYCLES, 50_000_000: clock cycles each stored point is shown before advancing to the next slot; must be ≥2.
- TARGET_X, 4'h2: X coordinate for the target-match compare (only used with the optional feature).
- TARGET_Y, 4'h8: Y coordinate for the target-match compare (only used with the optional feature).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- X  in  4  X coordinate of the point being entered.
- Y  in  4  Y coordinate of the point being entered.
- enter  in  1  entry strobe, already synchronised and debounced; level signal, edge-detected internally.
- disp_x  out  4  X of the slot currently displayed.
- disp_y  out  4  Y of the slot currently displayed.
- disp_slot  out  2  index of the slot currently displayed (0=A … 3=D).
- disp_valid  out  1  1 when disp_x/disp_y hold a stored point; 0 means blank the digits.
- count  out  3  number of stored points, 0..4.
- full  out  1  1 when count==4.
- overflow  out  1  sticky flag: an entry was attempted while full.
- hit  out  1  a stored point equals (TARGET_X,TARGET_Y); driven only with the optional feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - all slots invalid; count=0, full=0, overflow=0, hit=0.
  - disp_x=0, disp_y=0, disp_slot=0, disp_valid=0.
  - enter history register = 0; dwell counter = 0; state = EMPTY.
- Edge detect:
  - A capture event occurs on a clock edge where enter=1 and the registered previous sample of enter is 0.
  - Holding enter high produces exactly one event.
  - All effects of an event are visible on outputs after that same edge (1-cycle latency from sampling).
- FSM states:
  - EMPTY (count=0).
  - FILL (count 1..3).
  - FULL (count=4).
- On a capture event:
  - X==0 and Y==0, from any state → EMPTY. count=0, all slots invalid, overflow=0, disp_valid=0, dwell counter=0.
  - Non-zero point in EMPTY or FILL → store into slot[count]; count+1; go to FILL, or to FULL when the new count is 4.
  - Non-zero point in FULL → slots unchanged; overflow=1; state stays FULL.
- Display scheduler:
  - EMPTY: disp_valid=0, disp_x/disp_y/disp_slot=0, dwell counter held at 0.
  - When a point is stored: disp_slot jumps to the new slot, disp_x/disp_y show it, disp_valid=1, dwell counter restarts at 0.
  - Otherwise, in FILL or FULL, the dwell counter increments each cycle. At DWELL_CYCLES-1 it wraps to 0 and disp_slot advances to (disp_slot+1) mod count.
  - count==1: disp_slot stays at 0; the counter still wraps.
  - An ignored entry in FULL does not disturb the dwell counter or disp_slot.
  - disp_x/disp_y always equal the contents of slot[disp_slot].
- Width rules:
  - count is 3 bits and saturates at 4.
  - Dwell counter width is $clog2(DWELL_CYCLES).
  - Slot index arithmetic is 2-bit, with the wrap bounded by count.
- Simultaneous events: a capture event and a dwell wrap on the same edge → the capture wins; the display jumps to the new slot, or blanks on "0,0".

Optional Feature:
- Macro: TARGET_MATCH_EN.
- Defined:
  - hit is registered; it goes to 1 on the edge after any valid slot equals (TARGET_X,TARGET_Y).
  - hit clears on "0,0" entry or reset.
  - hit is unaffected by ignored FULL entries.
- Undefined:
  - hit tied to 0.
  - No compare logic is synthesised.
  - The port is still present.

Test Plan (bench uses DWELL_CYCLES=4):
- Reset released, enter pulses with (3,5) then (7,1) → count=2; disp_slot=1, disp=(7,1) immediately; after 4 cycles disp_slot=0, disp=(3,5); after 4 more, back to (7,1).
- enter held high 20 cycles with (4,4) → exactly one capture; count=1; disp_slot constant at 0.
- Five entries (1,1),(2,2),(3,3),(4,4),(9,9) → count=4, full=1, overflow=1; slot D holds (4,4); (9,9) is never displayed.
- From FULL, enter (0,0) → next cycle count=0, full=0, overflow=0, disp_valid=0, disp_x=disp_y=0.
- Assert reset mid-dwell with count=3 → outputs go to reset values immediately, without waiting for a clock edge; after release, the first entry lands in slot A.
- TARGET_MATCH_EN defined, enter (5,5) then (2,8) → hit=0 after the first entry, 1 after the second; enter (0,0) → hit=0. Without the macro, hit=0 throughout.
